pool_2: RTL and testbench
=========================

Name: pool_2

Overview:
- 2x2, stride-2 max-pooling stage that consumes conv2 output from the shared result BRAM.
- Reads 50 feature maps of 8x8 at base 14400 and writes 50 pooled maps of 4x4 at base 17600 in the same BRAM.
- Started and stopped by the top-level layer sequencer with the same en/finish handshake as the conv stages, and runs after conv_2 finishes.
- Only BRAM master in the design that reads conv2 results.

Parameters:
- CHANNELS, 50, number of feature maps.
- IN_SIZE, 8, input map edge.
- OUT_SIZE, 4, output map edge (IN_SIZE/2).
- DATA_SIZE, 8, element width; signed two's complement.
- SRC_BASE, 14400, first conv2 result address.
- DST_BASE, 17600, first pool2 result address.
- RD_LAT, 3, cycles from issuing a BRAM address to sampling douta.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- pool_2_en  in  1  run enable from the sequencer.
- result_bram_douta  in  8  BRAM read data.
- result_bram_ena  out  1  BRAM enable.
- result_bram_wea  out  1  BRAM write enable.
- result_bram_addra  out  15  BRAM address.
- result_bram_dina  out  8  BRAM write data.
- pool_2_finish  out  1  layer complete.

Behaviour:
- Reset: one clock; rst is asynchronous and active-low. While rst=0, all outputs are 0, state=IDLE, and all counters (channel, row, col, k, circle) are 0.
- Enable:
  - While pool_2_en=0 outside DONE, the FSM holds: no state, counter or output change. BRAM signals keep their values, so an in-flight access stretches.
  - In DONE, pool_2_en=0 returns the FSM to IDLE.
- IDLE:
  - Clear counters and max_reg; pool_2_finish=0.
  - Next state CHECK when en=1.
- CHECK:
  - If channel==CHANNELS: ena=0, wea=0, pool_2_finish=1, go to DONE.
  - Else: k=0, circle=0, go to LOAD.
- LOAD: four reads for window element k=0..3, with dy=k[1] and dx=k[0].
  - circle 0: ena=1, wea=0, addra = SRC_BASE + channel*64 + (2*row+dy)*8 + 2*col+dx.
  - circle RD_LAT: sample douta.
    - k=0: max_reg = sample.
    - k>0: max_reg = signed max(max_reg, sample).
    - Then k++ and circle=0.
  - Other cycles: circle++.
  - After k=3 is sampled: ena=0, go to STORE.
- STORE:
  - circle 0: ena=1, wea=1, addra = DST_BASE + channel*16 + row*4 + col, dina = max_reg.
  - circle RD_LAT: ena=0, wea=0, advance col, then row, then channel (col wraps 3->0 and increments row; row wraps 3->0 and increments channel), go to CHECK.
  - Other cycles: circle++.
- DONE: pool_2_finish held at 1 while en=1. When en=0: finish=0, go to IDLE. No BRAM activity.
- Comparison: 8-bit signed; ties keep the current max_reg (value identical).
- Timing:
  - Per output: 16 load + 4 store + 1 check = 21 cycles.
  - Full layer: 800 outputs = 16800 cycles, plus IDLE and final CHECK.
  - The first read address appears 3 cycles after en rises from reset-released IDLE.
- Address range:
  - Reads: 14400..17599.
  - Writes: 17600..18399.
  - Never writes below DST_BASE.
- Reset mid-operation aborts immediately. Any partially written output is left in BRAM and is rewritten on the next run.
- Latching: douta is sampled only at circle RD_LAT with ena=1 issued at circle 0. Nothing is sampled while en=0.

Test Plan:
- BRAM model (3-cycle read latency) preloaded with 14400+i = i mod 128 as signed; run with en held -> address 17600 holds max(0,1,8,9)=9, address 17601 holds 11, finish rises after ~16800 cycles, and the last write is to 18399.
- Window {-128,-1,-5,-128} at channel 0, row 0, col 0 -> 17600 = 8'hFF (-1); window {-128,-128,-128,-128} -> 8'h80.
- Drop en for 50 cycles mid-LOAD at channel 7 -> no addra/ena/circle change while low; after resume, final BRAM contents match the uninterrupted run.
- Assert rst low asynchronously mid-STORE -> all outputs 0 within the same cycle; a rerun from IDLE produces correct contents.
- Finish handshake: finish stays 1 while en=1 with no further BRAM traffic; en=0 -> finish=0 next edge, FSM in IDLE; re-raising en reruns the layer.
- Write monitor over a full run -> exactly 800 writes, each address 17600..18399 written exactly once, and zero writes to 14400..17599.

Source files
------------

// File: rtl/pool_2.sv
// pool_2: 2x2 stride-2 signed max pooling of conv2 results held in the shared result BRAM.
// Reads IN_SIZE x IN_SIZE maps at SRC_BASE, writes OUT_SIZE x OUT_SIZE maps at DST_BASE.
module pool_2 #(
   parameter int unsigned CHANNELS  = 50,
   parameter int unsigned IN_SIZE   = 8,
   parameter int unsigned OUT_SIZE  = 4,
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned SRC_BASE  = 14400,
   parameter int unsigned DST_BASE  = 17600,
   parameter int unsigned RD_LAT    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pool_2_en,
   input  logic [DATA_SIZE-1:0] result_bram_douta,
   output logic                 result_bram_ena,
   output logic                 result_bram_wea,
   output logic [14:0]          result_bram_addra,
   output logic [DATA_SIZE-1:0] result_bram_dina,
   output logic                 pool_2_finish
);

   localparam int unsigned ADDR_W   = 15;
   localparam int unsigned CH_W     = $clog2(CHANNELS + 1);
   localparam int unsigned POS_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
   localparam int unsigned CIR_W    = $clog2(RD_LAT + 1);
   localparam int unsigned K_W      = 2;
   localparam int unsigned IN_AREA  = IN_SIZE * IN_SIZE;
   localparam int unsigned OUT_AREA = OUT_SIZE * OUT_SIZE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_LOAD,
      S_STORE,
      S_DONE
   } state_t;

   state_t               state_q,   state_d;
   logic [CH_W-1:0]      channel_q, channel_d;
   logic [POS_W-1:0]     row_q,     row_d;
   logic [POS_W-1:0]     col_q,     col_d;
   logic [K_W-1:0]       k_q,       k_d;
   logic [CIR_W-1:0]     circle_q,  circle_d;
   logic [DATA_SIZE-1:0] max_q,     max_d;
   logic                 ena_q,     ena_d;
   logic                 wea_q,     wea_d;
   logic [ADDR_W-1:0]    addra_q,   addra_d;
   logic [DATA_SIZE-1:0] dina_q,    dina_d;
   logic                 finish_q,  finish_d;

   logic [ADDR_W-1:0]    src_addr_c;
   logic [ADDR_W-1:0]    dst_addr_c;

   // Window element k selects row offset k[1] and column offset k[0].
   assign src_addr_c = ADDR_W'(SRC_BASE)
                     + ADDR_W'(channel_q) * ADDR_W'(IN_AREA)
                     + ADDR_W'({row_q, k_q[1]}) * ADDR_W'(IN_SIZE)
                     + ADDR_W'({col_q, k_q[0]});

   assign dst_addr_c = ADDR_W'(DST_BASE)
                     + ADDR_W'(channel_q) * ADDR_W'(OUT_AREA)
                     + ADDR_W'(row_q) * ADDR_W'(OUT_SIZE)
                     + ADDR_W'(col_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         channel_q <= '0;
         row_q     <= '0;
         col_q     <= '0;
         k_q       <= '0;
         circle_q  <= '0;
         max_q     <= '0;
         ena_q     <= 1'b0;
         wea_q     <= 1'b0;
         addra_q   <= '0;
         dina_q    <= '0;
         finish_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         channel_q <= channel_d;
         row_q     <= row_d;
         col_q     <= col_d;
         k_q       <= k_d;
         circle_q  <= circle_d;
         max_q     <= max_d;
         ena_q     <= ena_d;
         wea_q     <= wea_d;
         addra_q   <= addra_d;
         dina_q    <= dina_d;
         finish_q  <= finish_d;
      end
   end

   // Everything holds while en is low, except DONE which uses en=0 to return to IDLE.
   always_comb begin
      state_d   = state_q;
      channel_d = channel_q;
      row_d     = row_q;
      col_d     = col_q;
      k_d       = k_q;
      circle_d  = circle_q;
      max_d     = max_q;
      ena_d     = ena_q;
      wea_d     = wea_q;
      addra_d   = addra_q;
      dina_d    = dina_q;
      finish_d  = finish_q;

      if (state_q == S_DONE) begin
         if (!pool_2_en) begin
            finish_d = 1'b0;
            state_d  = S_IDLE;
         end
      end else if (pool_2_en) begin
         unique case (state_q)
            S_IDLE: begin
               channel_d = '0;
               row_d     = '0;
               col_d     = '0;
               k_d       = '0;
               circle_d  = '0;
               max_d     = '0;
               finish_d  = 1'b0;
               state_d   = S_CHECK;
            end
            S_CHECK: begin
               if (channel_q == CH_W'(CHANNELS)) begin
                  ena_d    = 1'b0;
                  wea_d    = 1'b0;
                  finish_d = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  k_d      = '0;
                  circle_d = '0;
                  state_d  = S_LOAD;
               end
            end
            S_LOAD: begin
               if (circle_q == '0) begin
                  ena_d    = 1'b1;
                  wea_d    = 1'b0;
                  addra_d  = src_addr_c;
                  circle_d = circle_q + 1'b1;
               end else if (circle_q == CIR_W'(RD_LAT)) begin
                  // Strict compare keeps the held max on ties.
                  if (k_q == '0 || $signed(result_bram_douta) > $signed(max_q)) begin
                     max_d = result_bram_douta;
                  end
                  k_d      = k_q + 1'b1;
                  circle_d = '0;
                  if (k_q == K_W'(3)) begin
                     ena_d   = 1'b0;
                     state_d = S_STORE;
                  end
               end else begin
                  circle_d = circle_q + 1'b1;
               end
            end
            S_STORE: begin
               if (circle_q == '0) begin
                  ena_d    = 1'b1;
                  wea_d    = 1'b1;
                  addra_d  = dst_addr_c;
                  dina_d   = max_q;
                  circle_d = circle_q + 1'b1;
               end else if (circle_q == CIR_W'(RD_LAT)) begin
                  ena_d    = 1'b0;
                  wea_d    = 1'b0;
                  circle_d = '0;
                  state_d  = S_CHECK;
                  if (col_q == POS_W'(OUT_SIZE - 1)) begin
                     col_d = '0;
                     if (row_q == POS_W'(OUT_SIZE - 1)) begin
                        row_d     = '0;
                        channel_d = channel_q + 1'b1;
                     end else begin
                        row_d = row_q + 1'b1;
                     end
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end else begin
                  circle_d = circle_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   assign result_bram_ena   = ena_q;
   assign result_bram_wea   = wea_q;
   assign result_bram_addra = addra_q;
   assign result_bram_dina  = dina_q;
   assign pool_2_finish     = finish_q;

endmodule

// File: tb/tb_pool_2.sv
// Scoreboard bench for pool_2: a BRAM model feeds the DUT, expected writes are queued per run
// and a negedge monitor pops one entry per write transaction.
module tb_pool_2;

   localparam int unsigned SRC  = 14400;
   localparam int unsigned DST  = 17600;
   localparam int unsigned NOUT = 800;
   localparam int unsigned BOUND = 20000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pool_2_en = 1'b0;
   logic [7:0]  douta = 8'h00;
   logic        ena, wea, finish;
   logic [14:0] addra;
   logic [7:0]  dina;

   pool_2 dut (
      .clk               (clk),
      .rst               (rst),
      .pool_2_en         (pool_2_en),
      .result_bram_douta (douta),
      .result_bram_ena   (ena),
      .result_bram_wea   (wea),
      .result_bram_addra (addra),
      .result_bram_dina  (dina),
      .pool_2_finish     (finish)
   );

   always #5 clk = ~clk;

   // BRAM model: read data appears in douta on the second enabled edge after the address.
   logic [7:0] mem [0:32767];
   logic [7:0] rd1 = 8'h00;
   always @(posedge clk) begin
      if (ena) begin
         if (wea) mem[addra] <= dina;
         rd1   <= mem[addra];
         douta <= rd1;
      end
   end

   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: one scoreboard pop per write transaction (rising ena&wea).
   logic        wr_prev  = 1'b0;
   int          wr_total = 0;
   int          wr_low   = 0;
   int          wcnt [NOUT];
   logic [14:0] last_wr  = '0;
   wr_t         got;

   initial foreach (wcnt[i]) wcnt[i] = 0;

   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         wr_prev = 1'b0;
      end else begin
         if (ena && wea && !wr_prev) begin
            wr_total++;
            last_wr = addra;
            if (addra < 15'(DST)) wr_low++;
            else if (addra < 15'(DST + NOUT)) wcnt[addra - 15'(DST)]++;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL write_unexpected: addr %0d data %0h with empty scoreboard", addra, dina);
            end else begin
               got = exp_q.pop_front();
               check("write_addr", 32'(addra), 32'(got.addr));
               check("write_data", 32'(dina), 32'(got.data));
            end
         end
         wr_prev = ena && wea;
      end
   end

   function automatic logic [7:0] pmax(input int ch, input int r, input int c);
      logic signed [7:0] m, v;
      m = '0;
      for (int k = 0; k < 4; k++) begin
         v = $signed(mem[SRC + ch*64 + (2*r + k/2)*8 + 2*c + k%2]);
         if (k == 0 || v > m) m = v;
      end
      return m;
   endfunction

   task automatic push_all();
      for (int ch = 0; ch < 50; ch++)
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               exp_q.push_back(wr_t'{addr: 15'(DST + ch*16 + r*4 + c), data: pmax(ch, r, c)});
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_to_finish(input string name, output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!finish && cyc < BOUND);
      check(name, 32'(finish), 32'd1);
   endtask

   task automatic wait_for(input string name, input logic w, input logic [14:0] a);
      int n;
      n = 0;
      while (!(ena && wea == w && addra == a) && n < BOUND) begin
         step();
         n++;
      end
      check(name, 32'(ena && wea == w && addra == a), 32'd1);
   endtask

   int         cyc, bad;
   int         wsnap [NOUT];
   logic [7:0] gold  [NOUT];
   logic [25:0] snap;

   initial begin
      for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
      for (int i = 0; i < 3200; i++) mem[SRC + i] = 8'(i % 128);
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({ena, wea, addra, dina, finish}), 32'd0);
      rst = 1'b1;
      step();
      check("idle_no_enable", 32'({ena, wea, finish}), 32'd0);

      // Run A: ramp data, en held throughout
      push_all();
      wsnap = wcnt;
      pool_2_en = 1'b1;
      step();
      step();
      check("no_read_after_2_edges", 32'(ena), 32'd0);
      step();
      check("first_read_ena", 32'(ena), 32'd1);
      check("first_read_addr", 32'(addra), 32'(SRC));
      run_to_finish("runA_finish", cyc);
      check("runA_cycles", 32'(cyc + 3), 32'd16802);
      check("mem_17600", 32'(mem[17600]), 32'd9);
      check("mem_17601", 32'(mem[17601]), 32'd11);
      check("last_write_addr", 32'(last_wr), 32'd18399);
      check("write_count", 32'(wr_total), 32'd800);
      check("writes_below_dst", 32'(wr_low), 32'd0);
      bad = 0;
      for (int i = 0; i < NOUT; i++) if (wcnt[i] - wsnap[i] != 1) bad++;
      check("each_addr_once", 32'(bad), 32'd0);
      check("queue_empty_A", 32'(exp_q.size()), 32'd0);

      // Finish handshake
      bad = 0;
      repeat (20) begin
         step();
         if (!finish || ena || wea) bad++;
      end
      check("done_hold", 32'(bad), 32'd0);
      pool_2_en = 1'b0;
      step();
      check("finish_drop", 32'(finish), 32'd0);

      // Run B: negative windows and an all-minimum tie window
      mem[SRC + 0]  = 8'h80;
      mem[SRC + 1]  = 8'hFF;
      mem[SRC + 8]  = 8'hFB;
      mem[SRC + 9]  = 8'h80;
      mem[SRC + 2]  = 8'h80;
      mem[SRC + 3]  = 8'h80;
      mem[SRC + 10] = 8'h80;
      mem[SRC + 11] = 8'h80;
      push_all();
      pool_2_en = 1'b1;
      run_to_finish("runB_finish", cyc);
      check("neg_window", 32'(mem[17600]), 32'hFF);
      check("min_window", 32'(mem[17601]), 32'h80);
      check("queue_empty_B", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < NOUT; i++) gold[i] = mem[DST + i];
      pool_2_en = 1'b0;
      step();

      // Run C: en dropped for 50 cycles mid-LOAD at channel 7
      for (int i = 0; i < NOUT; i++) mem[DST + i] = 8'h00;
      push_all();
      pool_2_en = 1'b1;
      wait_for("reach_ch7_load", 1'b0, 15'(SRC + 7*64 + 1));
      step();
      pool_2_en = 1'b0;
      snap = {ena, wea, addra, dina, finish};
      bad = 0;
      repeat (50) begin
         step();
         if ({ena, wea, addra, dina, finish} !== snap) bad++;
      end
      check("stall_hold", 32'(bad), 32'd0);
      pool_2_en = 1'b1;
      run_to_finish("runC_finish", cyc);
      bad = 0;
      for (int i = 0; i < NOUT; i++) if (mem[DST + i] !== gold[i]) bad++;
      check("stall_contents", 32'(bad), 32'd0);
      check("queue_empty_C", 32'(exp_q.size()), 32'd0);
      pool_2_en = 1'b0;
      step();

      // Run D: asynchronous reset mid-STORE, then a clean rerun
      push_all();
      pool_2_en = 1'b1;
      wait_for("reach_store", 1'b1, 15'(DST + 100));
      #2;
      rst = 1'b0;
      pool_2_en = 1'b0;
      #1;
      check("async_reset_outputs", 32'({ena, wea, addra, dina, finish}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      mem[DST + 100] = 8'hAA;
      push_all();
      pool_2_en = 1'b1;
      run_to_finish("runD_finish", cyc);
      bad = 0;
      for (int i = 0; i < NOUT; i++) if (mem[DST + i] !== gold[i]) bad++;
      check("rerun_contents", 32'(bad), 32'd0);
      check("queue_empty_D", 32'(exp_q.size()), 32'd0);
      pool_2_en = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
